// File: rtl/debouncer.sv
// Switch debouncer: a 2-flop synchronizer feeding a four-state qualification FSM.
// A new level is accepted only after BOUNCE_TICKS+1 consecutive ena samples agree.
module debouncer #(
    parameter int N            = 8,
    parameter int BOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic bouncy_in,
    output logic out,
    output logic positive_edge,
    output logic negative_edge
);

    typedef enum logic [1:0] {
        S_LOW        = 2'b00,
        S_MAYBE_HIGH = 2'b01,
        S_HIGH       = 2'b10,
        S_MAYBE_LOW  = 2'b11
    } state_t;

    localparam logic [N-1:0] LAST = N'(BOUNCE_TICKS - 1);

    logic         sync_p0;
    logic         sync_p1;
    logic         synced;
    state_t       state;
    logic [N-1:0] cnt;

    // Synchronizer runs every cycle, independent of the sample strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= bouncy_in;
            sync_p1 <= sync_p0;
        end
    end

    assign synced = sync_p1;

    // Qualification FSM; edge pulses self-clear on the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_LOW;
            cnt           <= '0;
            out           <= 1'b0;
            positive_edge <= 1'b0;
            negative_edge <= 1'b0;
        end else begin
            positive_edge <= 1'b0;
            negative_edge <= 1'b0;
            if (ena) begin
                case (state)
                    S_LOW: begin
                        if (synced) begin
                            state <= S_MAYBE_HIGH;
                            cnt   <= '0;
                        end
                    end
                    S_MAYBE_HIGH: begin
                        if (!synced) begin
                            state <= S_LOW;
                        end else if (cnt == LAST) begin
                            state         <= S_HIGH;
                            cnt           <= '0;
                            out           <= 1'b1;
                            positive_edge <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (!synced) begin
                            state <= S_MAYBE_LOW;
                            cnt   <= '0;
                        end
                    end
                    S_MAYBE_LOW: begin
                        if (synced) begin
                            state <= S_HIGH;
                        end else if (cnt == LAST) begin
                            state         <= S_LOW;
                            cnt           <= '0;
                            out           <= 1'b0;
                            negative_edge <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_LOW;
                        cnt   <= '0;
                        out   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: BOUNCE_TICKS=4 and BOUNCE_TICKS=1 instances share stimulus;
// a run-length reference model feeds a queue of expected outputs.
module tb_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic bin = 1'b0;
    logic out4, pe4, ne4;
    logic out1, pe1, ne1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0] e4;
        logic [2:0] e1;
    } exp_t;
    exp_t sb_q[$];

    // model state, index 0 -> BOUNCE_TICKS=4, index 1 -> BOUNCE_TICKS=1
    logic m_s0[2];
    logic m_s1[2];
    logic m_out[2];
    logic m_pe[2];
    logic m_ne[2];
    int   m_run[2];

    always #5 clk = ~clk;

    debouncer #(.N(8), .BOUNCE_TICKS(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena), .bouncy_in(bin),
        .out(out4), .positive_edge(pe4), .negative_edge(ne4)
    );

    debouncer #(.N(8), .BOUNCE_TICKS(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .bouncy_in(bin),
        .out(out1), .positive_edge(pe1), .negative_edge(ne1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: count consecutive ena samples where synced differs from out
    task automatic model(input int k, input int b);
        m_pe[k] = 1'b0;
        m_ne[k] = 1'b0;
        if (rst) begin
            m_s0[k]  = 1'b0;
            m_s1[k]  = 1'b0;
            m_out[k] = 1'b0;
            m_run[k] = 0;
        end else begin
            if (ena) begin
                if (m_s1[k] != m_out[k]) begin
                    m_run[k]++;
                    if (m_run[k] == b + 1) begin
                        m_out[k] = ~m_out[k];
                        m_pe[k]  = m_out[k];
                        m_ne[k]  = ~m_out[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s1[k] = m_s0[k];
            m_s0[k] = bin;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic b);
        exp_t x;
        rst = r;
        ena = e;
        bin = b;
        model(0, 4);
        model(1, 1);
        sb_q.push_back({{m_out[0], m_pe[0], m_ne[0]}, {m_out[1], m_pe[1], m_ne[1]}});
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check("b4_out_pe_ne", {29'd0, out4, pe4, ne4}, {29'd0, x.e4});
        check("b1_out_pe_ne", {29'd0, out1, pe1, ne1}, {29'd0, x.e1});
        check("b4_excl", {31'd0, pe4 & ne4}, 32'd0);
    endtask

    task automatic do_reset(input logic b);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, b);
    endtask

    initial begin
        int rise_at;
        int fall_at;
        int npos;
        int nneg;
        int ena_cnt;
        logic rb;
        logic rr;
        logic re;

        // Reset state
        do_reset(1'b0);
        check("reset_out", {31'd0, out4}, 32'd0);
        check("reset_pe", {31'd0, pe4}, 32'd0);
        check("reset_ne", {31'd0, ne4}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // Short 3-cycle glitch is rejected
        npos = 0; nneg = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, (i < 3));
            npos += pe4; nneg += ne4;
        end
        check("glitch_out", {31'd0, out4}, 32'd0);
        check("glitch_pulses", npos + nneg, 0);

        // Clean rise: out and positive_edge at edge 6, pulse one cycle
        rise_at = -1; npos = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (out4 && rise_at < 0) rise_at = i;
            if (pe4 && i == 6) check("rise_pe_at_6", {31'd0, pe4}, 32'd1);
            npos += pe4;
        end
        check("rise_edge", rise_at, 6);
        check("rise_pulse_count", npos, 1);
        check("rise_hold", {31'd0, out4}, 32'd1);

        // Toggle 1,0,1,0 then hold low: single negative_edge
        fall_at = -1; nneg = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, i[0] ? 1'b0 : 1'b1);
            nneg += ne4;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i < 3) check("toggle_out_high", {31'd0, out4}, 32'd1);
            nneg += ne4;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            nneg += ne4;
        end
        check("fall_out", {31'd0, out4}, 32'd0);
        check("fall_pulse_count", nneg, 1);

        // ena every third cycle: accepted on 5th ena edge after synced reads 1
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        rise_at = -1; ena_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, (i % 3 == 0), 1'b1);
            if (i >= 2 && (i % 3 == 0)) ena_cnt++;
            if (out4 && rise_at < 0) begin
                rise_at = i;
                check("slow_ena_count", ena_cnt, 5);
            end
        end
        check("slow_rise_edge", rise_at, 15);

        // Reset mid-count in S_MAYBE_HIGH, then full requalification
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        rise_at = -1; npos = 0;
        for (int i = 0; i < 16; i++) begin
            step((i == 5), 1'b1, 1'b1);
            if (i == 5) check("midrst_out", {31'd0, out4}, 32'd0);
            if (out4 && rise_at < 0) rise_at = i;
            npos += pe4;
        end
        check("midrst_rise_edge", rise_at, 12);
        check("midrst_pulse_count", npos, 1);

        // Input high through reset: rise at 7th edge after release
        do_reset(1'b1);
        rise_at = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (out4 && rise_at < 0) begin
                rise_at = i;
                check("held_pe", {31'd0, pe4}, 32'd1);
            end
        end
        check("held_rise_edge", rise_at, 7);

        // Random mix of strobes, bounces and occasional resets
        rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) rb = ~rb;
            re = ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 59) == 0);
            step(rr, re, rb);
        end

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
